// File: rtl/hcsr04_ranging.sv
// hcsr04_ranging
// HC-SR04 style ultrasonic ranging front end. Fires a trigger pulse once per
// period, times the echo pulse in microseconds, scales the time to
// millimetres and converts the result to packed BCD for the display stage.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   echo          sensor echo (asynchronous to clk)
//   trig          sensor trigger
//   distance_data packed BCD distance in mm ([3:0] mm, [7:4] cm units,
//                 [11:8] cm tens, [15:12] cm hundreds, [19:16] cm thousands,
//                 [23:20] zero)
//   data_vld      one-cycle strobe, distance_data/echo_err valid alongside
//   echo_err      1 when the last measurement timed out
module hcsr04_ranging #(
   parameter int CLK_FREQ        = 50_000_000,
   parameter int TRIG_US         = 10,
   parameter int PERIOD_MS       = 60,
   parameter int ECHO_TIMEOUT_US = 38000,
   parameter int MAX_MM          = 4000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        echo,
   output logic        trig,
   output logic [23:0] distance_data,
   output logic        data_vld,
   output logic        echo_err
);

   localparam int DIV = CLK_FREQ / 1_000_000;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
   localparam logic [15:0] TIMEOUT_CNT = 16'(ECHO_TIMEOUT_US);
   localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_MS - 1);
   localparam logic [13:0] MAX_MM_W = 14'(MAX_MM);
   localparam logic [13:0] MM_SCALE = 14'd11239;

   typedef enum logic [2:0] {
      IDLE, TRIG, WAIT_RISE, MEASURE, CALC, TIMEOUT, CONV, DONE
   } state_t;

   state_t state, state_nxt;

   logic [DIV_W-1:0] us_div;
   logic             us_tick;
   logic [9:0]       us_in_ms;
   logic [15:0]      ms_cnt;
   logic             running;
   logic             period_start;

   logic echo_m, echo_s, echo_d;
   logic echo_rise, echo_fall;

   logic [15:0] us_cnt;
   logic [15:0] echo_us;
   logic        us_clr, us_inc, capture;

   logic [29:0] prod;
   logic [13:0] mm_raw, mm_sat;
   logic [15:0] bin_sr;
   logic [19:0] bcd, bcd_adj, bcd_next;
   logic [3:0]  conv_cnt;
   logic        err_r;

   // Microsecond tick is registered so it is low in the first cycle after
   // reset; this phases the ticks so TRIG lasts exactly TRIG_US*DIV clocks.
   // The period restarts when the ms counters wrap, and once right after
   // reset release so the first trigger does not wait a whole period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_div   <= '0;
         us_tick  <= 1'b0;
         us_in_ms <= '0;
         ms_cnt   <= '0;
         running  <= 1'b0;
      end else begin
         running <= 1'b1;
         us_tick <= (us_div == DIV_LAST);
         if (us_div == DIV_LAST) us_div <= '0;
         else                    us_div <= us_div + DIV_W'(1);
         if (us_tick) begin
            if (us_in_ms == 10'd999) begin
               us_in_ms <= '0;
               if (ms_cnt == PERIOD_LAST) ms_cnt <= '0;
               else                       ms_cnt <= ms_cnt + 16'd1;
            end else begin
               us_in_ms <= us_in_ms + 10'd1;
            end
         end
      end
   end

   assign period_start = !running ||
                         (us_tick && (us_in_ms == 10'd999) && (ms_cnt == PERIOD_LAST));

   // Two-flop synchroniser plus a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise = echo_s && !echo_d;
   assign echo_fall = !echo_s && echo_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A fall is checked before the timeout so a simultaneous fall counts as
   // a valid measurement. trig is decoded from the state so it drops as
   // soon as reset asserts.
   always_comb begin
      state_nxt = state;
      trig      = 1'b0;
      data_vld  = 1'b0;
      us_clr    = 1'b0;
      us_inc    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            us_clr = 1'b1;
            if (period_start) state_nxt = TRIG;
         end
         TRIG: begin
            trig = 1'b1;
            if (us_tick) begin
               if (us_cnt == TRIG_LAST) begin
                  state_nxt = WAIT_RISE;
                  us_clr    = 1'b1;
               end else begin
                  us_inc = 1'b1;
               end
            end
         end
         WAIT_RISE: begin
            if (echo_rise) begin
               state_nxt = MEASURE;
               us_clr    = 1'b1;
            end else if (us_cnt >= TIMEOUT_CNT) begin
               state_nxt = TIMEOUT;
            end else if (us_tick) begin
               us_inc = 1'b1;
            end
         end
         MEASURE: begin
            if (echo_fall) begin
               state_nxt = CALC;
               capture   = 1'b1;
            end else if (us_cnt >= TIMEOUT_CNT) begin
               state_nxt = TIMEOUT;
            end else if (us_tick) begin
               us_inc = 1'b1;
            end
         end
         CALC:    state_nxt = CONV;
         TIMEOUT: state_nxt = CONV;
         CONV: begin
            if (conv_cnt == 4'd15) state_nxt = DONE;
         end
         DONE: begin
            data_vld  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mm = us * 11239 / 65536 approximates us * 0.1715 (half the speed of sound).
   always_comb begin
      prod   = 30'(echo_us) * 30'(MM_SCALE);
      mm_raw = 14'(prod >> 16);
      mm_sat = (mm_raw > MAX_MM_W) ? MAX_MM_W : mm_raw;
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift in the
   // next binary bit.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
      bcd_next = 20'({bcd_adj, bin_sr[15]});
   end

   // The binary input is widened to 16 bits so that the conversion always
   // takes exactly 16 steps. Outputs are loaded on the last step so they are
   // valid in the DONE cycle, and are held until the next result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt        <= '0;
         echo_us       <= '0;
         bin_sr        <= '0;
         bcd           <= '0;
         conv_cnt      <= '0;
         err_r         <= 1'b0;
         distance_data <= '0;
         echo_err      <= 1'b0;
      end else begin
         if (us_clr)      us_cnt <= '0;
         else if (us_inc) us_cnt <= us_cnt + 16'd1;
         if (capture) echo_us <= us_cnt;
         if (state == CALC) begin
            bin_sr   <= {2'b00, mm_sat};
            bcd      <= '0;
            conv_cnt <= '0;
            err_r    <= 1'b0;
         end else if (state == TIMEOUT) begin
            bin_sr   <= {2'b00, MAX_MM_W};
            bcd      <= '0;
            conv_cnt <= '0;
            err_r    <= 1'b1;
         end else if (state == CONV) begin
            bin_sr   <= bin_sr << 1;
            bcd      <= bcd_next;
            conv_cnt <= conv_cnt + 4'd1;
            if (conv_cnt == 4'd15) begin
               distance_data <= {4'h0, bcd_next};
               echo_err      <= err_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_hcsr04_ranging.sv
// tb_hcsr04_ranging
// Self-checking bench for hcsr04_ranging, run with a scaled-down clock and
// period so that a full sequence of measurements stays short. Expected
// distances are computed by a reference model when the echo stimulus is
// driven and queued; a monitor pops and compares them on every data_vld.
module tb_hcsr04_ranging;

   localparam int CLK_FREQ    = 2_000_000;
   localparam int DIV         = CLK_FREQ / 1_000_000;
   localparam int TRIG_US     = 10;
   localparam int PERIOD_MS   = 3;
   localparam int TIMEOUT_US  = 2500;
   localparam int MAX_MM      = 400;
   localparam int TRIG_CLKS   = TRIG_US * DIV;
   localparam int PERIOD_CLKS = PERIOD_MS * 1000 * DIV;
   localparam int VLD_LATENCY = 20;

   logic        clk;
   logic        rst_n;
   logic        echo;
   logic        trig;
   logic [23:0] distance_data;
   logic        data_vld;
   logic        echo_err;

   int checks = 0;
   int errors = 0;

   logic [24:0] sbQueue[$];

   int   negCount = 0;
   int   riseAt   = 0;
   logic havePrev = 1'b0;
   logic prevTrig = 1'b0;

   hcsr04_ranging #(
      .CLK_FREQ       (CLK_FREQ),
      .TRIG_US        (TRIG_US),
      .PERIOD_MS      (PERIOD_MS),
      .ECHO_TIMEOUT_US(TIMEOUT_US),
      .MAX_MM         (MAX_MM)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .echo         (echo),
      .trig         (trig),
      .distance_data(distance_data),
      .data_vld     (data_vld),
      .echo_err     (echo_err)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #(200_000 * 20);
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [23:0] toBcd(input int mm);
      logic [23:0] r;
      r        = '0;
      r[3:0]   = 4'(mm % 10);
      r[7:4]   = 4'((mm / 10) % 10);
      r[11:8]  = 4'((mm / 100) % 10);
      r[15:12] = 4'((mm / 1000) % 10);
      r[19:16] = 4'((mm / 10000) % 10);
      return r;
   endfunction

   function automatic logic [23:0] expectDist(input int us);
      longint p;
      int     mm;
      p  = longint'(us) * 64'd11239;
      mm = int'(p / 65536) & 32'h3FFF;
      if (mm > MAX_MM) mm = MAX_MM;
      return toBcd(mm);
   endfunction

   // Trigger width/period and scoreboard monitor.
   always @(negedge clk) begin
      logic [24:0] exp;
      negCount++;
      if (!rst_n) begin
         havePrev = 1'b0;
         prevTrig = 1'b0;
      end else begin
         if (trig && !prevTrig) begin
            if (havePrev) checkOutput("trig_period", negCount - riseAt, PERIOD_CLKS);
            riseAt   = negCount;
            havePrev = 1'b1;
         end
         if (!trig && prevTrig) checkOutput("trig_width", negCount - riseAt, TRIG_CLKS);
         prevTrig = trig;
         if (data_vld) begin
            if (sbQueue.size() == 0) begin
               checkOutput("sb_unexpected_vld", 1, 0);
            end else begin
               exp = sbQueue.pop_front();
               checkOutput("distance_data", distance_data, exp[23:0]);
               checkOutput("echo_err", echo_err, exp[24]);
            end
         end
      end
   end

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitTrigFall();
      int k;
      k = 0;
      while (!trig && k < PERIOD_CLKS + 100) begin
         @(negedge clk);
         k++;
      end
      checkOutput("trig_rise_seen", trig, 1);
      k = 0;
      while (trig && k < TRIG_CLKS + 10) begin
         @(negedge clk);
         k++;
      end
      checkOutput("trig_fall_seen", !trig, 1);
   endtask

   // Valid echo of widthUs, starting delayUs after the trigger falls.
   task automatic applyStimulus(input int delayUs, input int widthUs);
      int lat;
      waitTrigFall();
      waitClocks(delayUs * DIV);
      echo = 1'b1;
      waitClocks(widthUs * DIV);
      sbQueue.push_back({1'b0, expectDist(widthUs)});
      echo = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (data_vld) begin
            lat = k;
            break;
         end
      end
      checkOutput("vld_latency", lat, VLD_LATENCY);
   endtask

   // mode 0: no echo; mode 1: echo already high across the trigger, dropped
   // during the wait; mode 2: echo rises then stays high past the timeout.
   task automatic applyTimeout(input int mode);
      int   k;
      logic seen;
      waitTrigFall();
      if (mode == 2) begin
         waitClocks(100 * DIV);
         echo = 1'b1;
      end
      sbQueue.push_back({1'b1, toBcd(MAX_MM)});
      seen = 1'b0;
      k = 0;
      while (!seen && k < (TIMEOUT_US + 100) * DIV) begin
         @(negedge clk);
         k++;
         if (mode == 1 && k == 200 * DIV) echo = 1'b0;
         if (data_vld) seen = 1'b1;
      end
      checkOutput("timeout_vld_seen", seen, 1);
      checkOutput("timeout_window", (k >= TIMEOUT_US * DIV) && (k <= TIMEOUT_US * DIV + 40), 1);
      echo = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      echo  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_trig", trig, 0);
      checkOutput("reset_vld", data_vld, 0);
      checkOutput("reset_data", distance_data, 0);
      checkOutput("reset_err", echo_err, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("trig_before_first_edge", trig, 0);
      @(negedge clk);
      checkOutput("trig_first_edge", trig, 1);

      applyStimulus(100, 1000);
      applyStimulus(100, 2000);
      applyStimulus(100, 1500);
      applyStimulus(100, 10);
      applyStimulus(100, 2345);
      applyTimeout(0);
      applyStimulus(100, 1000);
      echo = 1'b1;
      applyTimeout(1);
      applyTimeout(2);

      waitTrigFall();
      waitClocks(100 * DIV);
      echo = 1'b1;
      waitClocks(500 * DIV);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_trig", trig, 0);
      checkOutput("async_reset_vld", data_vld, 0);
      checkOutput("async_reset_data", distance_data, 0);
      checkOutput("async_reset_err", echo_err, 0);
      echo = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("restart_trig_low", trig, 0);
      @(negedge clk);
      checkOutput("restart_trig_high", trig, 1);
      applyStimulus(100, 1000);

      waitClocks(10);
      checkOutput("sb_empty", sbQueue.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hcsr04_ranging.md
Name: hcsr04_ranging

Overview:
- Ultrasonic (HC-SR04 style) ranging front end; directly upstream of the distance plotting/display stage.
- Issues periodic trigger pulses and times the sensor's echo pulse in microseconds.
- Converts the echo time to millimetres, then to packed BCD.
- Presents the result as distance_data with a one-cycle data_vld strobe.

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz; microsecond tick divisor = CLK_FREQ/1_000_000.
- TRIG_US, 10: trigger high time in us.
- PERIOD_MS, 60: trigger-start to trigger-start interval in ms.
- ECHO_TIMEOUT_US, 38000: maximum wait for echo rise, and maximum echo high time, in us.
- MAX_MM, 4000: distance reported on timeout, in mm.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- echo  in  1  sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger.
- distance_data  out  24  packed BCD distance in mm:
  - [3:0] mm (0.1 cm)
  - [7:4] cm units
  - [11:8] cm tens
  - [15:12] cm hundreds
  - [19:16] cm thousands
  - [23:20] always 0
- data_vld  out  1  one-cycle strobe; distance_data and echo_err are valid in the same cycle.
- echo_err  out  1  1 = last measurement timed out.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: trig=0, distance_data=0, data_vld=0, echo_err=0, FSM=IDLE, all counters 0.
  - Assertion mid-operation aborts immediately; trig drops asynchronously.
- Echo input: double-flop synchronised to echo_s.
  - Rise = echo_s 0->1 between consecutive cycles; fall = 1->0.
  - Echo activity outside WAIT_RISE/MEASURE is ignored.
- us_tick: one-cycle pulse every CLK_FREQ/1_000_000 clocks from a free-running divider, cleared at reset.
- Period counter: counts ms; TRIG is entered when it wraps to 0.
  - The first trigger starts on the first clk edge after reset release.
  - The period is independent of the measurement outcome.
  - Since ECHO_TIMEOUT_US < PERIOD_MS*1000, every measurement completes before the next trigger.
- FSM:
  - IDLE: trig=0; wait for period start -> TRIG.
  - TRIG: trig=1 for TRIG_US us_ticks -> WAIT_RISE, with trig=0 and us counter cleared.
  - WAIT_RISE:
    - rise -> MEASURE, us counter cleared.
    - us counter reaching ECHO_TIMEOUT_US -> TIMEOUT.
    - echo already high on entry is not a rise.
  - MEASURE: us counter increments per us_tick.
    - fall -> CALC, echo_us = count.
    - count reaching ECHO_TIMEOUT_US -> TIMEOUT.
  - CALC (1 cycle): mm = (echo_us * 11239) >> 16, a 16x14 unsigned multiply truncated to 14 bits; mm is saturated to MAX_MM; err=0 -> CONV.
  - TIMEOUT (1 cycle): mm = MAX_MM, err=1 -> CONV.
  - CONV: sequential shift-add-3 binary-to-BCD, exactly 16 cycles -> DONE.
  - DONE (1 cycle): load distance_data and echo_err, data_vld=1 -> IDLE.
- Latency: registered fall -> data_vld is 18 cycles (CALC 1 + CONV 16 + DONE 1).
- distance_data and echo_err hold their values between strobes.
- data_vld never asserts more than once per trigger period.
- An echo fall and a timeout in the same cycle resolve as the fall, i.e. a valid measurement.

Test Plan:
- Reset release, echo tied 0: trig high exactly 500 clks (10 us) starting 1 clk after release; next trig rises 3_000_000 clks after the first.
- Echo high 1000 us, starting 100 us after trig falls: data_vld 18 clks after registered fall; distance_data=24'h000171, echo_err=0.
- Echo widths 2000 us and 23324 us: distance_data=24'h000342 and 24'h003999 respectively.
- Echo never rises: data_vld 38000 us after trig fall; distance_data=24'h004000, echo_err=1. Next valid 1000 us echo clears echo_err and gives 24'h000171.
- Echo stuck high across trig: no rise is seen, so the measurement times out with echo_err=1. Echo held high 40000 us after a valid rise also gives echo_err=1, 24'h004000.
- rst_n asserted mid-MEASURE: trig=0, data_vld=0, distance_data=0 with no clock; the measurement restarts cleanly after release.
